truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
Sequential stimulus/capture stage that sits directly upstream of a 3-input combinational function block.
- Walks every input vector 0..2^N_IN-1 into the function and holds each vector for a programmable settle time.
- Samples the function's 1-bit response for each vector and assembles the measured truth table.
- Compares the measured table against an expected table and reports pass/fail, mismatch count and the first failing index.
- Replaces hand-written exhaustive input sweeps with a reusable on-chip/bench checker.

Parameters:
N_IN, 3, number of function inputs; vec width; table width TW = 2^N_IN.
SETTLE, 1, extra cycles each vector is held before its response is sampled (>=0); each vector occupies SETTLE+1 cycles.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a sweep; accepted only in IDLE.
abort  input  1  synchronous cancel of a running sweep.
exp_table  input  TW  expected truth table, bit i = expected response for vector i; latched at start acceptance.
resp  input  1  response of the downstream function for the current vec.
vec  output  N_IN  current input vector, MSB drives the function's first input.
busy  output  1  high while a sweep is in progress (DRIVE state).
done  output  1  one-cycle pulse when a sweep completes normally.
res_valid  output  1  results below are valid; set with done, cleared at next start acceptance, abort or reset.
meas_table  output  TW  measured truth table.
mismatch_cnt  output  N_IN+1  number of vectors where resp != expected (0..TW).
first_fail  output  N_IN  lowest failing vector index; 0 when none.
fail_seen  output  1  at least one mismatch recorded.
pass  output  1  res_valid && mismatch_cnt==0.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - vec, busy, done, res_valid, meas_table, mismatch_cnt, first_fail, fail_seen, pass and the settle counter all go to 0.
- State machine: IDLE, DRIVE, DONE.
- IDLE:
  - On start=1: latch exp_table; clear meas_table, mismatch_cnt, first_fail, fail_seen and res_valid; set vec=0 and cnt=0; go to DRIVE.
  - abort is ignored in IDLE.
- DRIVE:
  - busy=1.
  - If cnt<SETTLE: increment cnt.
  - If cnt==SETTLE: sample resp on this edge.
    - Set meas_table[vec] <= resp.
    - On resp != exp_latched[vec]: increment mismatch_cnt. If fail_seen==0, set first_fail<=vec and fail_seen<=1.
    - Then, if vec==TW-1: go to DONE. Otherwise increment vec and reset cnt to 0.
  - With SETTLE=0, sampling occurs every cycle and the counter is unused.
- DONE:
  - done=1 and res_valid<=1 for this one cycle.
  - vec holds TW-1.
  - Next state is IDLE unconditionally; start is not accepted in DONE.
- Latency: with start sampled at edge E, DRIVE occupies edges E+1..E+TW*(SETTLE+1). done is high in the cycle following edge E+TW*(SETTLE+1).
  - Defaults (N_IN=3, SETTLE=1): done asserts after edge E+16.
- start while busy or in DONE: ignored, with no effect on the running sweep.
- abort in DRIVE:
  - Next state IDLE; done not pulsed; res_valid stays 0.
  - Partial meas_table and counters are kept for debug.
  - vec returns to 0.
- abort and the final sample on the same edge: abort wins. No done pulse, res_valid=0.
- Results hold stable in IDLE until the next start acceptance.
- exp_table changes during a sweep have no effect, because the latched copy is used.
- Width rule: mismatch_cnt is N_IN+1 bits so that TW mismatches fit without wrap. vec increments with no wrap past TW-1.
- Reset mid-sweep: immediate return to the reset values; no done.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, DRIVE, DONE);
  - function for TW=1<<N_IN;
  - clog2-based width constant for the settle counter, min width 1;
  - default expected-table constant for the team's 3-input function, 8'h70.
- One natural sub-module: sweep_settle_counter.
  - Settle counter plus vector counter.
  - Outputs sample_en and last_vec.
  - Top level keeps the FSM and the compare/accumulate logic.

Test Plan:
- Clean pass: connect to a model computing a&~(b&c) (vec[2]=a), exp_table=8'h70, SETTLE=1, pulse start. Required: done one cycle after edge +16; meas_table=8'h70, mismatch_cnt=0, pass=1, fail_seen=0.
- Single mismatch: exp_table=8'h71, same function. Required: mismatch_cnt=1, first_fail=0, fail_seen=1, pass=0, meas_table=8'h70.
- Full mismatch: exp_table=8'h8F. Required: mismatch_cnt=8 (no wrap), first_fail=0, pass=0. Repeat with SETTLE=0: done after edge +8 with the same results.
- Busy-start/abort: start again at DRIVE cycle 5 -> ignored; sweep completes normally. New sweep, abort at cycle 6 -> IDLE, no done pulse, res_valid=0, vec=0.
- Abort coincident with final sample edge -> no done, res_valid=0. Subsequent start runs a full clean sweep with a correct pass.
- Reset: drop rst_n asynchronously mid-sweep (vec=3) -> all outputs 0 immediately. After release, start gives a correct full sweep. A change to exp_table during the sweep does not alter the result.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
// Imported by the top level and the settle/vector counter.
package truth_table_sweeper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Expected response of the team's 3-input function a & ~(b & c).
   localparam logic [7:0] DEFAULT_EXP_TABLE = 8'h70;

   function automatic int tw_of(input int n_in);
      return 1 << n_in;
   endfunction

   // The settle counter holds 0..SETTLE; it keeps at least one bit even when SETTLE is 0.
   function automatic int cnt_width(input int settle);
      return (settle < 2) ? 1 : $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Settle counter plus input-vector counter for the truth-table sweeper.
// Raises o_sample_en on the last settle cycle of each vector.
module sweep_settle_counter
   import truth_table_sweeper_pkg::*;
#(
   parameter  int N_IN   = 3,
   parameter  int SETTLE = 1,
   localparam int TW     = tw_of(N_IN),
   localparam int CW     = cnt_width(SETTLE)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_clear,
   input  logic            i_run,
   output logic [N_IN-1:0] o_vec,
   output logic            o_sample_en,
   output logic            o_last_vec
);

   localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);
   localparam logic [N_IN-1:0] LAST_C   = N_IN'(TW - 1);

   logic [CW-1:0]   r_cnt;
   logic [N_IN-1:0] r_vec;
   logic            w_at_settle;

   assign w_at_settle = (r_cnt == SETTLE_C);
   assign o_sample_en = i_run & w_at_settle;
   assign o_last_vec  = (r_vec == LAST_C);
   assign o_vec       = r_vec;

   // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_vec <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
         r_vec <= '0;
      end else if (i_run) begin
         if (!w_at_settle) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_cnt <= '0;
            // The last vector is held so DONE still shows TW-1.
            if (!o_last_vec) r_vec <= r_vec + N_IN'(1);
         end
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper: drives every vector into a combinational function,
// captures its response table and compares it against a latched expected table.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter  int N_IN   = 3,
   parameter  int SETTLE = 1,
   localparam int TW     = tw_of(N_IN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [TW-1:0]   exp_table,
   input  logic            resp,
   output logic [N_IN-1:0] vec,
   output logic            busy,
   output logic            done,
   output logic            res_valid,
   output logic [TW-1:0]   meas_table,
   output logic [N_IN:0]   mismatch_cnt,
   output logic [N_IN-1:0] first_fail,
   output logic            fail_seen,
   output logic            pass
);

   state_e          r_state;
   logic [TW-1:0]   r_exp;
   logic            r_busy, r_done, r_res_valid, r_fail_seen, r_pass;
   logic [TW-1:0]   r_meas;
   logic [N_IN:0]   r_mismatch_cnt;
   logic [N_IN-1:0] r_first_fail;

   logic            w_clear, w_run, w_sample_en, w_last_vec, w_mis;
   logic [N_IN-1:0] w_vec;
   logic [N_IN:0]   w_cnt_next;

   assign w_clear = ((r_state == ST_IDLE) && start) || ((r_state == ST_DRIVE) && abort);
   assign w_run   = (r_state == ST_DRIVE);

   sweep_settle_counter #(
      .N_IN   (N_IN),
      .SETTLE (SETTLE)
   ) u_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (w_clear),
      .i_run       (w_run),
      .o_vec       (w_vec),
      .o_sample_en (w_sample_en),
      .o_last_vec  (w_last_vec)
   );

   assign w_mis      = w_sample_en && (resp != r_exp[w_vec]);
   assign w_cnt_next = r_mismatch_cnt + (N_IN+1)'(w_mis);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_exp          <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_res_valid    <= 1'b0;
         r_meas         <= '0;
         r_mismatch_cnt <= '0;
         r_first_fail   <= '0;
         r_fail_seen    <= 1'b0;
         r_pass         <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_exp          <= exp_table;
                  r_meas         <= '0;
                  r_mismatch_cnt <= '0;
                  r_first_fail   <= '0;
                  r_fail_seen    <= 1'b0;
                  r_res_valid    <= 1'b0;
                  r_pass         <= 1'b0;
                  r_busy         <= 1'b1;
                  r_state        <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               // Abort outranks a coincident sample; partial results stay for debug.
               if (abort) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_sample_en) begin
                  r_meas[w_vec]  <= resp;
                  r_mismatch_cnt <= w_cnt_next;
                  if (w_mis && !r_fail_seen) begin
                     r_first_fail <= w_vec;
                     r_fail_seen  <= 1'b1;
                  end
                  if (w_last_vec) begin
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_res_valid <= 1'b1;
                     r_pass      <= (w_cnt_next == '0);
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign vec          = w_vec;
   assign busy         = r_busy;
   assign done         = r_done;
   assign res_valid    = r_res_valid;
   assign meas_table   = r_meas;
   assign mismatch_cnt = r_mismatch_cnt;
   assign first_fail   = r_first_fail;
   assign fail_seen    = r_fail_seen;
   assign pass         = r_pass;

endmodule
